demux_reg_bank: RTL



---
 rtl/demux_reg_bank_pkg.sv | 12 +
 rtl/dec_onehot.sv | 22 ++
 rtl/demux_reg_bank.sv | 128 ++++++++++++
 3 files changed

// File: rtl/demux_reg_bank_pkg.sv
// demux_reg_bank_pkg: shared types and default geometry for the demux register bank.
package demux_reg_bank_pkg;

    // Default geometry: 3 entries of 3 bits, 2-bit select.
    localparam int DEF_N = 3;
    localparam int DEF_M = 3;
    localparam int DEF_S = 2;

    // Controller states: normal operation or the clear sweep.
    typedef enum logic {S_IDLE, S_CLEAR} demux_state_t;

endpackage

// File: rtl/dec_onehot.sv
// dec_onehot: gated binary-to-one-hot decoder. An index with no matching
// entry (sel >= N) yields an all-zero vector, so it can never write anything.
module dec_onehot #(
    parameter int N = 3,
    parameter int S = 2
) (
    input  logic         en,
    input  logic [S-1:0] sel,
    output logic [N-1:0] onehot
);

    // One bit per entry, set only when enabled and the index matches.
    always_comb begin
        onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (en && (sel == S'(k))) begin
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_reg_bank.sv
// demux_reg_bank: N x M register bank written through a valid/ready port
// (1-to-N demux) with a sequenced clear sweep. Entry k is at bank[k*M +: M].
// Optional build macro DEMUX_REG_BANK_WR_ERR_EN enables the wr_err flag for
// accepted writes whose select has no matching entry.
//
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready.
// wr_ready is combinational, low while clearing and while clr_req is high;
// the master must hold wr_valid/wr_sel/wr_data until the transfer happens.
// busy is the exposed controller state (1 exactly when in S_CLEAR).
module demux_reg_bank
    import demux_reg_bank_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M,
    parameter int S = DEF_S
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [S-1:0]   wr_sel,
    input  logic [M-1:0]   wr_data,
    input  logic           clr_req,
    output logic           busy,
    output logic [N*M-1:0] bank,
    output logic           wr_err
);

    demux_state_t   state_q, state_d;
    logic [S-1:0]   cnt_q, cnt_d;
    logic [N*M-1:0] bank_q, bank_d;
    logic           wr_fire;
    logic [N-1:0]   wr_oh;
    logic [N-1:0]   clr_oh;

    assign wr_ready = (state_q == S_IDLE) && !clr_req;
    assign wr_fire  = wr_valid && wr_ready;
    assign busy     = (state_q == S_CLEAR);
    assign bank     = bank_q;

    // Write-enable decode: only the selected entry, only on a handshake.
    dec_onehot #(.N(N), .S(S)) u_dec_wr (
        .en     (wr_fire),
        .sel    (wr_sel),
        .onehot (wr_oh)
    );

    // Clear-enable decode: the entry pointed to by the sweep counter.
    dec_onehot #(.N(N), .S(S)) u_dec_clr (
        .en     (busy),
        .sel    (cnt_q),
        .onehot (clr_oh)
    );

    // Next state and sweep counter; requests during a sweep are ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == S'(N - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + S'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bank next value: clear and write never overlap since wr_ready is low while clearing.
    always_comb begin
        bank_d = bank_q;
        for (int k = 0; k < N; k++) begin
            if (clr_oh[k]) begin
                bank_d[k*M +: M] = '0;
            end else if (wr_oh[k]) begin
                bank_d[k*M +: M] = wr_data;
            end
        end
    end

    // State, counter and bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
        end
    end

`ifdef DEMUX_REG_BANK_WR_ERR_EN
    logic wr_err_q, wr_err_d;

    // Flag a transfer that decoded to no entry, for the cycle after the edge.
    always_comb begin
        wr_err_d = wr_fire && (wr_oh == '0);
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;
`else
    assign wr_err = 1'b0;
`endif

endmodule
